// File: rtl/cache_control.sv
// Sequencing FSM for a 4-way set-associative write-back cache: drives datapath strobes and
// memory-side handshakes, and keeps saturating hit/miss/writeback counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a CPU request; tag/data arrays being read
// COMPARE   | tag compare result valid; hit completes, miss picks a path
// WRITEBACK | dirty PLRU victim being written to memory
// ALLOCATE  | line being fetched from memory into the PLRU victim way
// REFILL    | one-cycle settle so the refilled line is readable, then COMPARE
module cache_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             is_hit,
  input  logic             is_dirty,
  output logic             is_allocate,
  output logic             use_replace,
  output logic             load_data,
  output logic             load_tag,
  output logic             load_valid,
  output logic             load_dirty,
  output logic             load_plru,
  output logic             valid_in,
  output logic             dirty_in,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t state;
  state_t state_next;
  logic   first_cmp;
  logic   req;
  logic   hit_inc;
  logic   miss_inc;
  logic   wb_inc;

  assign req = mem_read | mem_write;

  // Outputs are gated by rst so an abort never produces an array write.
  always_comb begin
    state_next  = state;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    is_allocate = 1'b0;
    use_replace = 1'b0;
    load_data   = 1'b0;
    load_tag    = 1'b0;
    load_valid  = 1'b0;
    load_dirty  = 1'b0;
    load_plru   = 1'b0;
    valid_in    = 1'b0;
    dirty_in    = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    wb_inc      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req) state_next = COMPARE;
        end
        COMPARE: begin
          if (is_hit) begin
            mem_resp  = 1'b1;
            load_plru = 1'b1;
            if (mem_write) begin
              load_data  = 1'b1;
              load_dirty = 1'b1;
              dirty_in   = 1'b1;
            end
            hit_inc    = first_cmp;
            state_next = IDLE;
          end else begin
            miss_inc   = first_cmp;
            state_next = is_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write  = 1'b1;
          use_replace = 1'b1;
          if (pmem_resp) begin
            load_dirty = 1'b1;
            wb_inc     = 1'b1;
            state_next = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read   = 1'b1;
          use_replace = 1'b1;
          is_allocate = 1'b1;
          if (pmem_resp) begin
            load_data  = 1'b1;
            load_tag   = 1'b1;
            load_valid = 1'b1;
            valid_in   = 1'b1;
            load_dirty = 1'b1;
            state_next = REFILL;
          end
        end
        REFILL: state_next = COMPARE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      first_cmp <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      wb_cnt    <= '0;
    end else begin
      state <= state_next;
      // Only the first COMPARE of a request is counted; the post-refill one is not.
      if (state == IDLE && req) first_cmp <= 1'b1;
      else if (state == COMPARE) first_cmp <= 1'b0;
      if (hit_inc && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      if (wb_inc && wb_cnt != '1) wb_cnt <= wb_cnt + 1'b1;
    end
  end

endmodule
